mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported 32-bit main memory between the instruction-fetch port and the load/store port of the MIPS core. Each cycle it grants at most one requester, drives the memory port, and routes the one-cycle-later read data back to the requester that issued it. Data accesses have priority; a starvation counter guarantees instruction fetch forward progress. The block sits between the core's fetch/LSU request logic and the synchronous memory macro.

## Interface
Parameters:
- ADDR_W, 18, word-address width (256K words).
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch request issued to memory this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  byte enables for writes; bit i covers bits [8i+7:8i]; ignored on reads.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data request issued this cycle.
- d_rvalid  out  1  data read data valid (reads only).
- d_rdata  out  32  data read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.

## Operation
- Grant (combinational from current inputs and state):
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both: if_gnt=1 when starve_cnt == STARVE_LIMIT, else d_gnt=1.
  - At most one gnt is high per cycle.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - For a fetch grant: mem_we=0, mem_be=4'hF, mem_addr=if_addr.
  - For a data grant: mem_we=d_we, mem_be = d_we ? d_be : 4'hF, mem_addr=d_addr, mem_wdata=d_wdata.
  - When mem_en=0: all mem_* outputs are 0.
- starve_cnt: width 4.
  - Cleared when if_req=0 or if_gnt=1.
  - Otherwise incremented when if_req=1 and d_gnt=1, saturating at STARVE_LIMIT.
- Response tag register (rsp_if, rsp_d):
  - Next value: rsp_if = if_gnt; rsp_d = d_gnt & ~d_we.
  - if_rvalid = rsp_if; d_rvalid = rsp_d.
  - if_rdata = rsp_if ? mem_rdata : 0; d_rdata = rsp_d ? mem_rdata : 0.
- Fully pipelined: a new grant may issue in the same cycle a previous read's data returns.
- Writes produce no rvalid.

## Timing
- Reset: if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid = 0; mem_be, mem_addr, mem_wdata, if_rdata, d_rdata = 0; starve_cnt = 0; tags cleared.
- While reset=1, requests are ignored (gnts forced 0).
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1. Sustained throughput is 1 access/cycle.
- Write: memory updated at the end of grant cycle N. A read of the same address granted in N+1 returns the new data.
- Reset asserted in cycle N+1 after a read grant in N: rvalid is suppressed and the response is dropped.
- Fetch worst-case wait under continuous data requests: STARVE_LIMIT cycles, granted in the (STARVE_LIMIT+1)th cycle.
- Deasserting a request before its grant is illegal. The arbiter does not latch requests.

## Test plan
- Single fetch: mem[0x10]=0x24020005, if_req with if_addr=0x10 in cycle 1 -> if_gnt=1 in cycle 1, if_rvalid=1 and if_rdata=0x24020005 in cycle 2, d_rvalid=0.
- Write then read: d_req write d_addr=0x40, d_wdata=0xDEADBEEF, d_be=F, followed next cycle by a read of 0x40 -> d_rvalid in the cycle after the read grant with d_rdata=0xDEADBEEF. No rvalid for the write.
- Byte enables: mem[0x40]=0xDEADBEEF; write d_wdata=0x000000AA with d_be=4'b0001, then read -> 0xDEADBEAA.
- Starvation (STARVE_LIMIT=4): if_req and d_req held high continuously -> d_gnt in cycles 1–4, if_gnt in cycle 5, d_gnt in cycles 6–9, if_gnt in cycle 10. Exactly one gnt per cycle.
- Reset mid-read: data read granted in cycle N, reset=1 in cycle N+1 -> d_rvalid=0 and d_rdata=0 in N+1. All outputs are at reset values. starve_cnt=0 on release.
- Back-to-back alternation: fetch read 0x10 in cycle 1, data read 0x20 in cycle 2 (if_req low) -> if_rvalid in cycle 2 only, d_rvalid in cycle 3 only, each with the correct word.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 32-bit memory between the fetch
// port and the load/store port; data has priority, starvation counter
// guarantees fetch progress, read data is routed back one cycle later.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch read request (held until if_gnt)
//   if_gnt                fetch issued to memory this cycle
//   if_rvalid/if_rdata    fetch read response (one cycle after grant)
//   d_req/d_we/d_be       data request, write flag, write byte enables
//   d_addr/d_wdata        data word address and write data
//   d_gnt                 data request issued to memory this cycle
//   d_rvalid/d_rdata      data read response (reads only)
//   mem_*                 synchronous memory macro port
module mem_port_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       rsp_if_q, rsp_if_d;
    logic       rsp_d_q,  rsp_d_d;

    // Grant: data wins a collision unless fetch has waited LIMIT cycles.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (if_req && d_req) begin
                if (starve_q == LIMIT) if_gnt = 1'b1;
                else                   d_gnt  = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Memory drive; all fields forced to zero when idle.
    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (if_gnt) begin
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_we ? d_be : 4'hF;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = 4'h0;
        end else if (d_gnt && starve_q != LIMIT) begin
            starve_d = starve_q + 4'h1;
        end
        rsp_if_d = if_gnt;
        rsp_d_d  = d_gnt & ~d_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 4'h0;
            rsp_if_q <= 1'b0;
            rsp_d_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rsp_if_q <= rsp_if_d;
            rsp_d_q  <= rsp_d_d;
        end
    end

    // Reset in the response cycle drops the response immediately.
    assign if_rvalid = rsp_if_q & ~reset;
    assign d_rvalid  = rsp_d_q & ~reset;
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus against a memory macro model plus
// a cycle-by-cycle reference model of arbitration and read responses.
module tb_mem_port_arbiter;

    localparam int AW  = 18;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [3:0]    d_be = 4'h0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = 32'h0;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro driven by the DUT.
    logic [31:0] macro_mem [int];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                logic [31:0] w;
                w = macro_mem.exists(int'(mem_addr)) ? macro_mem[int'(mem_addr)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                macro_mem[int'(mem_addr)] = w;
            end else begin
                mem_rdata <= macro_mem.exists(int'(mem_addr)) ? macro_mem[int'(mem_addr)] : 32'h0;
            end
        end
    end

    // Golden memory owned by the reference model.
    logic [31:0] gold [int];

    function automatic logic [31:0] gold_rd(input int a);
        return gold.exists(a) ? gold[a] : 32'h0;
    endfunction

    task automatic preload(input int a, input logic [31:0] v);
        macro_mem[a] = v;
        gold[a] = v;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: fetch wait count, pending response, golden data.
    int          m_wait = 0;
    logic        m_if_rv = 1'b0, m_d_rv = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    always @(negedge clk) begin
        logic        e_ig, e_dg;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd;
        logic        e_irv, e_drv;
        e_ig = 1'b0; e_dg = 1'b0;
        if (!reset) begin
            if (if_req && d_req) begin
                e_ig = (m_wait >= LIM);
                e_dg = !e_ig;
            end else begin
                e_ig = if_req;
                e_dg = d_req;
            end
        end
        e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
        if (e_ig) begin
            e_be = 4'hF; e_addr = 32'(if_addr);
        end else if (e_dg) begin
            e_we = d_we; e_be = d_we ? d_be : 4'hF;
            e_addr = 32'(d_addr); e_wd = d_wdata;
        end
        e_irv = m_if_rv && !reset;
        e_drv = m_d_rv && !reset;
        chk("m_if_gnt", 32'(if_gnt), 32'(e_ig));
        chk("m_d_gnt", 32'(d_gnt), 32'(e_dg));
        chk("m_mem_en", 32'(mem_en), 32'(e_ig | e_dg));
        chk("m_mem_we", 32'(mem_we), 32'(e_we));
        chk("m_mem_be", 32'(mem_be), 32'(e_be));
        chk("m_mem_addr", 32'(mem_addr), e_addr);
        chk("m_mem_wdata", mem_wdata, e_wd);
        chk("m_if_rvalid", 32'(if_rvalid), 32'(e_irv));
        chk("m_d_rvalid", 32'(d_rvalid), 32'(e_drv));
        chk("m_if_rdata", if_rdata, e_irv ? m_rdata : 32'h0);
        chk("m_d_rdata", d_rdata, e_drv ? m_rdata : 32'h0);
        // advance model to next cycle
        m_if_rv = e_ig;
        m_d_rv = e_dg && !d_we;
        if (e_ig) m_rdata = gold_rd(int'(if_addr));
        else if (e_dg && !d_we) m_rdata = gold_rd(int'(d_addr));
        if (e_dg && d_we) begin
            logic [31:0] w;
            w = gold_rd(int'(d_addr));
            for (int b = 0; b < 4; b++)
                if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
            gold[int'(d_addr)] = w;
        end
        if (!reset && if_req && !e_ig) m_wait++;
        else m_wait = 0;
    end

    // One cycle: drive after the edge, return at the mid-cycle sample point.
    task automatic cyc(input logic rst, input logic ir, input int ia,
                       input logic dr, input logic we, input logic [3:0] be,
                       input int da, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reset = rst; if_req = ir; if_addr = AW'(ia);
        d_req = dr; d_we = we; d_be = be; d_addr = AW'(da); d_wdata = wd;
        @(negedge clk);
    endtask

    // Idle cycle with junk on the non-request fields.
    task automatic idle();
        cyc(1'b0, 1'b0, 'h3, 1'b0, 1'b1, 4'h6, 'h7, 32'h5555_AAAA);
    endtask

    initial begin
        preload('h10, 32'h2402_0005);
        preload('h20, 32'h1111_2222);
        @(negedge clk);
        cyc(1'b1, 1'b1, 'h10, 1'b1, 1'b0, 4'hF, 'h20, 32'h0);
        chk("rst_if_gnt", 32'(if_gnt), 32'h0);
        chk("rst_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        idle();

        // single fetch
        cyc(1'b0, 1'b1, 'h10, 1'b0, 1'b0, 4'h0, 'h0, 32'h0);
        chk("fetch_gnt", 32'(if_gnt), 32'h1);
        chk("fetch_mem_be", 32'(mem_be), 32'hF);
        idle();
        chk("fetch_rvalid", 32'(if_rvalid), 32'h1);
        chk("fetch_rdata", if_rdata, 32'h2402_0005);
        chk("fetch_no_drv", 32'(d_rvalid), 32'h0);

        // write then read, read carries a partial d_be that must be ignored
        cyc(1'b0, 1'b0, 'h0, 1'b1, 1'b1, 4'hF, 'h40, 32'hDEAD_BEEF);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        cyc(1'b0, 1'b0, 'h0, 1'b1, 1'b0, 4'h2, 'h40, 32'h0);
        chk("wr_no_rvalid", 32'(d_rvalid), 32'h0);
        chk("rd_mem_be", 32'(mem_be), 32'hF);
        idle();
        chk("rd_rvalid", 32'(d_rvalid), 32'h1);
        chk("rd_rdata", d_rdata, 32'hDEAD_BEEF);

        // byte-enable write
        cyc(1'b0, 1'b0, 'h0, 1'b1, 1'b1, 4'b0001, 'h40, 32'h0000_00AA);
        chk("be_mem_be", 32'(mem_be), 32'h1);
        cyc(1'b0, 1'b0, 'h0, 1'b1, 1'b0, 4'hF, 'h40, 32'h0);
        idle();
        chk("be_rdata", d_rdata, 32'hDEAD_BEAA);

        // back-to-back alternation
        cyc(1'b0, 1'b1, 'h10, 1'b0, 1'b0, 4'h0, 'h0, 32'h0);
        cyc(1'b0, 1'b0, 'h0, 1'b1, 1'b0, 4'hF, 'h20, 32'h0);
        chk("alt_if_rv", 32'(if_rvalid), 32'h1);
        chk("alt_if_rdata", if_rdata, 32'h2402_0005);
        chk("alt_d_rv_early", 32'(d_rvalid), 32'h0);
        idle();
        chk("alt_if_rv_once", 32'(if_rvalid), 32'h0);
        chk("alt_d_rdata", d_rdata, 32'h1111_2222);
        idle();
        chk("alt_d_rv_once", 32'(d_rvalid), 32'h0);

        // starvation: fetch wins in cycles 5 and 10
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b1, 'h10, 1'b1, 1'b0, 4'hF, 'h20, 32'h0);
            chk($sformatf("starve_if_%0d", k), 32'(if_gnt), 32'(k == 5 || k == 10));
            chk($sformatf("starve_d_%0d", k), 32'(d_gnt), 32'(k != 5 && k != 10));
        end
        idle();

        // reset mid-read
        cyc(1'b0, 1'b0, 'h0, 1'b1, 1'b0, 4'hF, 'h20, 32'h0);
        cyc(1'b1, 1'b1, 'h10, 1'b1, 1'b0, 4'hF, 'h20, 32'h0);
        chk("rstmid_d_rv", 32'(d_rvalid), 32'h0);
        chk("rstmid_d_rdata", d_rdata, 32'h0);
        chk("rstmid_gnt", 32'(if_gnt | d_gnt), 32'h0);
        // after release fetch needs a full LIMIT wait again
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 1'b1, 'h10, 1'b1, 1'b0, 4'hF, 'h20, 32'h0);
            chk($sformatf("rel_if_%0d", k), 32'(if_gnt), 32'(k == 5));
        end

        // sustained data reads, one per cycle
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b0, 'h0, 1'b1, 1'b0, 4'hF, (k % 2) ? 'h20 : 'h40, 32'h0);
        chk("stream_rdata", d_rdata, 32'hDEAD_BEAA);
        idle();
        chk("stream_last", d_rdata, 32'h1111_2222);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
